// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port word memory.
// One access in flight at a time: IDLE -> ACCESS -> RESP -> IDLE.
module mem_arbiter #(
  parameter bit RR_ENABLE     = 1'b1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [31:0]              p0_addr,
  input  logic [31:0]              p0_wdata,
  output logic                     p0_gnt,
  output logic                     p0_rsp_valid,
  output logic [31:0]              p0_rdata,
  output logic [1:0]               p0_err,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [31:0]              p1_addr,
  input  logic [31:0]              p1_wdata,
  output logic                     p1_gnt,
  output logic                     p1_rsp_valid,
  output logic [31:0]              p1_rdata,
  output logic [1:0]               p1_err,
  output logic                     mem_r_en,
  output logic                     mem_w_en,
  output logic [31:0]              mem_r_addr,
  output logic [31:0]              mem_w_addr,
  output logic [31:0]              mem_w_data,
  input  logic [31:0]              mem_r_data,
  input  logic [1:0]               mem_state,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t state, state_nx;

  logic        owner, owner_nx;
  logic        last, last_nx;
  logic        cmd_we, cmd_we_nx;
  logic [31:0] cmd_addr, cmd_addr_nx;
  logic [31:0] cmd_wdata, cmd_wdata_nx;

  logic        gnt0_nx, gnt1_nx;
  logic        v0_nx, v1_nx;
  logic        ren_nx, wen_nx;
  logic        busy_nx;
  logic [31:0] rdata0_nx, rdata1_nx;
  logic [1:0]  err0_nx, err1_nx;
  logic [31:0] rsp_data;
  logic        win;

  logic [ERR_CNT_WIDTH-1:0] cnt_nx;

  // last = port of the previous grant; the other port wins a tie
  assign win = p1_req & (~p0_req | (RR_ENABLE & ~last));

  assign rsp_data = (!cmd_we && mem_state == 2'b00)
                  ? mem_r_data : 32'h0;

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    last_nx      = last;
    cmd_we_nx    = cmd_we;
    cmd_addr_nx  = cmd_addr;
    cmd_wdata_nx = cmd_wdata;
    gnt0_nx      = 1'b0;
    gnt1_nx      = 1'b0;
    v0_nx        = 1'b0;
    v1_nx        = 1'b0;
    ren_nx       = 1'b0;
    wen_nx       = 1'b0;
    rdata0_nx    = p0_rdata;
    rdata1_nx    = p1_rdata;
    err0_nx      = p0_err;
    err1_nx      = p1_err;
    cnt_nx       = err_count;
    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          owner_nx     = win;
          last_nx      = win;
          cmd_we_nx    = win ? p1_we    : p0_we;
          cmd_addr_nx  = win ? p1_addr  : p0_addr;
          cmd_wdata_nx = win ? p1_wdata : p0_wdata;
          gnt0_nx      = ~win;
          gnt1_nx      = win;
          ren_nx       = ~cmd_we_nx;
          wen_nx       = cmd_we_nx;
          state_nx     = ACCESS;
        end
      end
      ACCESS: state_nx = RESP;
      RESP: begin
        state_nx = IDLE;
        if (owner) begin
          v1_nx     = 1'b1;
          rdata1_nx = rsp_data;
          err1_nx   = mem_state;
        end else begin
          v0_nx     = 1'b1;
          rdata0_nx = rsp_data;
          err0_nx   = mem_state;
        end
        if (mem_state != 2'b00 && err_count != '1)
          cnt_nx = err_count + CNT_ONE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      cmd_we       <= 1'b0;
      cmd_addr     <= 32'h0;
      cmd_wdata    <= 32'h0;
      p0_gnt       <= 1'b0;
      p1_gnt       <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rdata     <= 32'h0;
      p1_rdata     <= 32'h0;
      p0_err       <= 2'b00;
      p1_err       <= 2'b00;
      mem_r_en     <= 1'b0;
      mem_w_en     <= 1'b0;
      busy         <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_nx;
      owner        <= owner_nx;
      last         <= last_nx;
      cmd_we       <= cmd_we_nx;
      cmd_addr     <= cmd_addr_nx;
      cmd_wdata    <= cmd_wdata_nx;
      p0_gnt       <= gnt0_nx;
      p1_gnt       <= gnt1_nx;
      p0_rsp_valid <= v0_nx;
      p1_rsp_valid <= v1_nx;
      p0_rdata     <= rdata0_nx;
      p1_rdata     <= rdata1_nx;
      p0_err       <= err0_nx;
      p1_err       <= err1_nx;
      mem_r_en     <= ren_nx;
      mem_w_en     <= wen_nx;
      busy         <= busy_nx;
      err_count    <= cnt_nx;
    end
  end

  assign mem_r_addr = cmd_addr;
  assign mem_w_addr = cmd_addr;
  assign mem_w_data = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default, fixed-priority and 2-bit
// counter instances share port stimulus, each with its own memory.
module tb_mem_arbiter;

  localparam int MW = 64;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic [2:0]  g0, g1, v0, v1, ren, wen, bz;
  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic [1:0]  e0 [3];
  logic [1:0]  e1 [3];
  logic [31:0] ra [3];
  logic [31:0] wa [3];
  logic [31:0] wd [3];
  logic [31:0] rdm [3];
  logic [1:0]  ms [3];
  logic [7:0]  ec0, ec1;
  logic [1:0]  ec2;

  int checks = 0;
  int errors = 0;
  bit collide = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(g0[0]), .p0_rsp_valid(v0[0]),
    .p0_rdata(rd0[0]), .p0_err(e0[0]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(g1[0]), .p1_rsp_valid(v1[0]),
    .p1_rdata(rd1[0]), .p1_err(e1[0]),
    .mem_r_en(ren[0]), .mem_w_en(wen[0]),
    .mem_r_addr(ra[0]), .mem_w_addr(wa[0]), .mem_w_data(wd[0]),
    .mem_r_data(rdm[0]), .mem_state(ms[0]),
    .busy(bz[0]), .err_count(ec0)
  );

  mem_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(g0[1]), .p0_rsp_valid(v0[1]),
    .p0_rdata(rd0[1]), .p0_err(e0[1]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(g1[1]), .p1_rsp_valid(v1[1]),
    .p1_rdata(rd1[1]), .p1_err(e1[1]),
    .mem_r_en(ren[1]), .mem_w_en(wen[1]),
    .mem_r_addr(ra[1]), .mem_w_addr(wa[1]), .mem_w_data(wd[1]),
    .mem_r_data(rdm[1]), .mem_state(ms[1]),
    .busy(bz[1]), .err_count(ec1)
  );

  mem_arbiter #(.ERR_CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(g0[2]), .p0_rsp_valid(v0[2]),
    .p0_rdata(rd0[2]), .p0_err(e0[2]),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(g1[2]), .p1_rsp_valid(v1[2]),
    .p1_rdata(rd1[2]), .p1_err(e1[2]),
    .mem_r_en(ren[2]), .mem_w_en(wen[2]),
    .mem_r_addr(ra[2]), .mem_w_addr(wa[2]), .mem_w_data(wd[2]),
    .mem_r_data(rdm[2]), .mem_state(ms[2]),
    .busy(bz[2]), .err_count(ec2)
  );

  // word memory: 11 unaligned, 10 out of range, 01 collision
  for (genvar k = 0; k < 3; k++) begin : g_mem
    logic [31:0] words [MW];
    always @(posedge clk) begin
      ms[k]  <= 2'b00;
      rdm[k] <= 32'h0;
      if (!rst_n) begin
        for (int i = 0; i < MW; i++) words[i] <= 32'h0;
        words[1] <= 32'h1111_1111;
        words[4] <= 32'hDEAD_BEEF;
      end else if (ren[k] && wen[k]) begin
        ms[k] <= 2'b01;
      end else if (ren[k]) begin
        if (ra[k][1:0] != 2'b00) begin
          ms[k]  <= 2'b11;
          rdm[k] <= words[ra[k][7:2]];
        end else if (ra[k] >= 32'(4 * MW)) begin
          ms[k]  <= 2'b10;
          rdm[k] <= 32'hBAD0_BAD0;
        end else begin
          rdm[k] <= words[ra[k][7:2]];
        end
      end else if (wen[k]) begin
        if (wa[k][1:0] != 2'b00) ms[k] <= 2'b11;
        else if (wa[k] >= 32'(4 * MW)) ms[k] <= 2'b10;
        else words[wa[k][7:2]] <= wd[k];
      end
    end
  end

  always @(negedge clk)
    if ((ren & wen) != 3'b000) collide = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit port, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rexp, input logic [1:0] eexp,
                        input string tag);
    if (!port) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
    tick();
    chk({tag, "_gnt"}, port ? g1[0] : g0[0], 32'd1);
    chk({tag, "_en"}, we ? wen[0] : ren[0], 32'd1);
    chk({tag, "_addr"}, we ? wa[0] : ra[0], addr);
    if (we) chk({tag, "_wdata"}, wd[0], wdata);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    chk({tag, "_early"}, port ? v1[0] : v0[0], 32'd0);
    tick();
    chk({tag, "_vld"}, port ? v1[0] : v0[0], 32'd1);
    chk({tag, "_rdata"}, port ? rd1[0] : rd0[0], rexp);
    chk({tag, "_err"}, 32'(port ? e1[0] : e0[0]), 32'(eexp));
    chk({tag, "_idle"}, bz[0], 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = 32'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h14; p1_wdata = 32'h0;
    repeat (3) tick();
    chk("rst_gnt0", g0[0], 32'd0);
    chk("rst_gnt1", g1[0], 32'd0);
    chk("rst_vld", {v0[0], v1[0]}, 32'd0);
    chk("rst_en", {ren[0], wen[0]}, 32'd0);
    chk("rst_busy", bz[0], 32'd0);
    chk("rst_rdata", rd0[0] | rd1[0], 32'd0);
    chk("rst_err", 32'({e0[0], e1[0]}), 32'd0);
    chk("rst_addr", ra[0] | wd[0], 32'd0);
    chk("rst_cnt", 32'(ec0), 32'd0);
    rst_n = 1'b1;

    // both ports request continuously from reset
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 3 == 1) begin
        chk($sformatf("rr_g0_c%0d", c), g0[0], 32'(c == 1 || c == 7));
        chk($sformatf("rr_g1_c%0d", c), g1[0], 32'(c == 4 || c == 10));
        chk($sformatf("fp_g0_c%0d", c), g0[1], 32'd1);
        chk($sformatf("fp_g1_c%0d", c), g1[1], 32'd0);
      end
      if (c == 2) chk("rr_busy", bz[0], 32'd1);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();

    access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00, "rd10");
    access(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, 2'b00, "wr20");
    access(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 2'b00, "rd20");

    access(1'b1, 1'b0, 32'h06, 32'h0, 32'h0, 2'b11, "unal");
    access(1'b0, 1'b0, 32'(4 * MW), 32'h0, 32'h0, 2'b10, "oob");
    chk("cnt2", 32'(ec0), 32'd2);
    chk("cnt2_w2", 32'(ec2), 32'd2);

    for (int i = 0; i < 5; i++)
      access(i[0], i[1], 32'(4 * i + 1), 32'h5555_0000 + 32'(i),
             32'h0, 2'b11, $sformatf("sat%0d", i));
    chk("cnt7", 32'(ec0), 32'd7);
    chk("cnt_sat", 32'(ec2), 32'd3);

    // reset while a read is in ACCESS
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    tick();
    chk("pre_gnt", g0[0], 32'd1);
    chk("pre_ren", ren[0], 32'd1);
    rst_n = 1'b0;
    p0_req = 1'b0;
    #1;
    chk("ar_gnt", g0[0], 32'd0);
    chk("ar_ren", ren[0], 32'd0);
    chk("ar_busy", bz[0], 32'd0);
    chk("ar_addr", ra[0], 32'd0);
    chk("ar_cnt", 32'(ec0), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("ar_vld%0d", c), v0[0], 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("ar_vld_rel", v0[0], 32'd0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00, "post");

    chk("no_collide", 32'(collide), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
